sm2201_interface_board: RTL and testbench
=========================================

Name: sm2201_interface_board

Overview:
ISA-bus (8-bit, I/O-mapped) to CAMAC crate controller bridge for the SM2201 board. The PC programs a CAMAC address (station/subaddress/crate), a function code and 16-bit data through byte registers, then the block runs one CAMAC transfer on the crate bus and returns read data and status to the PC. It sits between the ISA edge connector and the CAMAC branch cable.

Parameters:
BASE_ADDR, 10'h100, ISA I/O base; decode window is BASE_ADDR..BASE_ADDR+7.
CAMAC_TIMEOUT, 255, isa_clk cycles to wait for cb_zk4 before aborting a transfer.
IRQ_LINE, 5, isa_irq bit asserted by LAM; used only with the optional feature.

Ports:
isa_clk  in  1  sole clock.
isa_reset  in  1  asynchronous, active-low reset.
isa_ior  in  1  ISA I/O read strobe, active-low.
isa_iow  in  1  ISA I/O write strobe, active-low.
isa_addr  in  10  ISA I/O address.
isa_data  inout  8  ISA data bus.
isa_ale  in  1  address latch enable; accepted and ignored, because the address is stable for the whole strobe.
isa_aen  in  1  DMA address enable; while high, nothing is decoded.
isa_chrdy  out  1  I/O channel ready; low inserts wait states.
q_r_debug  out  1  high while a decoded ISA write strobe is active.
cb_prr  in  1  CAMAC LAM/request, active-low.
cb_zk4  in  1  CAMAC transfer-complete strobe, active-low.
cb_cx1  in  1  CAMAC X (command accepted) response, active-high.
cb_data  inout  16  CAMAC data bus.
cb_addr  out  12  CAMAC address, taken from AIR[11:0].
cb_b_b1  out  1  CAMAC direction; 1 = read cycle, so the crate drives cb_data.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0/1, DATA low/high. A write loads the write-data register. A read returns the captured read data.
  - 2, CMD. A write stores F[4:0] and starts a transfer, but only when idle; writes while busy are ignored. Reads return the stored F.
  - 4, STATUS, read-only: bit0 busy, bit1 X latched, bit2 LAM (~cb_prr synchronised), bit3 done, bit4 timeout. Reading STATUS clears done and timeout.
  - 6/7, AIR (address and interrupt register) low/high, read/write. Fields: [3:0] A, [8:4] N, [11:9] crate, [15] IRQ enable, [14:12] reserved and read back as written.
  - Offsets 3 and 5 read 0x00; writes to them are ignored.
- Decode: isa_aen==0 and isa_addr[9:3]==BASE_ADDR[9:3].
- ISA write:
  - isa_iow, isa_addr and isa_data are registered each clock.
  - Commit occurs on the clock that sees iow rise (previous 0, current 1), using the address and data registered during the low phase.
  - q_r_debug = decoded and isa_iow==0.
- ISA read: isa_data is driven only while decoded and isa_ior==0; otherwise it is high-Z. Data is combinational from the registers.
- isa_chrdy = 0 while a decoded read of DATA is in progress and busy==1; otherwise 1.
- CAMAC FSM:
  - IDLE → SETUP on CMD write.
  - SETUP (1 clk): cb_b_b1 = (F<16).
  - SETUP → WAIT; WAIT counts cycles.
  - WAIT → DONE on cb_zk4==0: capture cb_data (read) and cb_cx1.
  - WAIT → DONE with the timeout bit set when the count reaches CAMAC_TIMEOUT.
  - DONE → IDLE once cb_zk4 returns high or after a timeout. Sets done.
- cb_data is driven with the DATA register only when cb_b_b1==0 and the FSM is in SETUP or WAIT; otherwise it is high-Z.
- cb_addr follows AIR[11:0] at all times.
- Reset values: all registers 0, FSM IDLE, cb_b_b1=0, isa_chrdy=1, q_r_debug=0, both buses high-Z.
- Reset asserted mid-transfer aborts immediately, with no done flag.
- Simultaneous CPU write to DATA and a read capture: the capture has priority for read data; the write register is separate.

Optional Feature:
SM2201_ISA_IRQ_EN:
- Defined: adds output isa_irq[7:0]. Bit IRQ_LINE = AIR[15] & (LAM | done); all other bits are 0.
- Undefined: port absent; LAM and done remain visible only in STATUS.

Decomposition:
- Package sm2201_pkg: register offset constants, STATUS bit indices, AIR field positions, FSM state enum, and the read/write F threshold (16).
- One natural sub-module: sm2201_camac_cycle, holding the FSM, timeout counter, data capture and bus direction. The ISA decode and registers stay in the top.

Test Plan:
- AIR write: iow to 0x106 with 0xA6, then to 0x107 with 0x00 → cb_addr=12'h0A6; reading 0x106 returns 0xA6.
- CAMAC read: CMD=0x00 → cb_b_b1=1. Bench drives cb_data=16'h5A3C, pulls cb_zk4 low for 3 clks with cb_cx1=1 → DATA low reads 0x3C, high reads 0x5A; STATUS = 0x0A then 0x02 after the clearing read.
- CAMAC write: DATA=0x1234, CMD=0x10 → cb_b_b1=0 and DUT drives cb_data=0x1234 until cb_zk4 pulses low; done=1.
- Timeout: CMD=0x00 with cb_zk4 held high → after 255 clks, STATUS bit4=1, busy=0, cb_data high-Z.
- AEN/decode: write 0xFF to 0x106 with isa_aen=1, or to 0x0F0 → AIR unchanged; q_r_debug stays 0.
- Reset mid-transfer: isa_reset low during WAIT → FSM IDLE, cb_b_b1=0, all registers 0x00.

Source files
------------

// File: rtl/sm2201_pkg.sv
// sm2201_pkg: register map, status bits, AIR fields and CAMAC cycle states
package sm2201_pkg;
  localparam logic [2:0] OFF_DATA_LO = 3'd0;
  localparam logic [2:0] OFF_DATA_HI = 3'd1;
  localparam logic [2:0] OFF_CMD     = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd4;
  localparam logic [2:0] OFF_AIR_LO  = 3'd6;
  localparam logic [2:0] OFF_AIR_HI  = 3'd7;
  localparam int ST_BUSY = 0;
  localparam int ST_X    = 1;
  localparam int ST_LAM  = 2;
  localparam int ST_DONE = 3;
  localparam int ST_TMO  = 4;
  localparam int AIR_ADDR_MSB = 11;
  localparam int AIR_IRQ_EN   = 15;
  localparam logic [4:0] F_READ_LIMIT = 5'd16;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE} cyc_state_e;
endpackage

// File: rtl/sm2201_camac_cycle.sv
// sm2201_camac_cycle: one CAMAC transfer - direction, zk4 wait with timeout, capture, status flags
module sm2201_camac_cycle
  import sm2201_pkg::*;
#(
  parameter int CAMAC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        clr_i,
  input  logic [4:0]  f_i,
  input  logic        cb_zk4_i,
  input  logic        cb_cx1_i,
  input  logic [15:0] cb_data_i,
  output logic        busy_o,
  output logic        x_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        b1_o,
  output logic        drive_o,
  output logic [15:0] rdata_o
);
  localparam int CW = $clog2(CAMAC_TIMEOUT + 1);
  cyc_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic b1_q, b1_d, x_q, x_d, done_q, done_d, tmo_q, tmo_d;
  logic [15:0] rdata_q, rdata_d;
  logic hit;
  assign hit = cnt_q == CW'(CAMAC_TIMEOUT - 1);
  assign busy_o = state_q != S_IDLE;
  assign drive_o = !b1_q && (state_q == S_SETUP || state_q == S_WAIT);
  assign b1_o = b1_q;
  assign x_o = x_q;
  assign done_o = done_q;
  assign timeout_o = tmo_q;
  assign rdata_o = rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    b1_d = b1_q;
    x_d = x_q;
    rdata_d = rdata_q;
    done_d = done_q && !clr_i;
    tmo_d = tmo_q && !clr_i;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_SETUP;
        b1_d = f_i < F_READ_LIMIT;
        cnt_d = '0;
        x_d = 1'b0;
        done_d = 1'b0;
        tmo_d = 1'b0;
      end
      S_SETUP: state_d = S_WAIT;
      S_WAIT: if (!cb_zk4_i) begin
        state_d = S_DONE;
        x_d = cb_cx1_i;
        rdata_d = b1_q ? cb_data_i : rdata_q;
      end else if (hit) begin
        state_d = S_DONE;
        tmo_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_DONE: if (cb_zk4_i || tmo_q) begin
        state_d = S_IDLE;
        done_d = 1'b1;
        b1_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      b1_q <= 1'b0;
      x_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      b1_q <= b1_d;
      x_q <= x_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: rtl/sm2201_interface_board.sv
// sm2201_interface_board: ISA byte-register front end driving a CAMAC transfer engine.
// Define SM2201_ISA_IRQ_EN to add isa_irq[7:0] driven by LAM/done when AIR[15] is set.
module sm2201_interface_board
  import sm2201_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR     = 10'h100,
  parameter int         CAMAC_TIMEOUT = 255,
  parameter int         IRQ_LINE      = 5
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [9:0]  isa_addr,
  inout  wire  [7:0]  isa_data,
  input  logic        isa_ale,
  input  logic        isa_aen,
  output logic        isa_chrdy,
  output logic        q_r_debug,
  input  logic        cb_prr,
  input  logic        cb_zk4,
  input  logic        cb_cx1,
  inout  wire  [15:0] cb_data,
  output logic [11:0] cb_addr,
  output logic        cb_b_b1
`ifdef SM2201_ISA_IRQ_EN
  ,
  output logic [7:0]  isa_irq
`endif
);
  logic dec, dec_q, iow_q, ior_q, wr_stb, clr_stb, start;
  logic [2:0] off_q;
  logic [7:0] wdat_q, status, rd_mux;
  logic [15:0] wr_data_q, wr_data_d, air_q, air_d, rd_data;
  logic [4:0] f_q, f_d;
  logic lam_s_q, lam_q, busy, x_lat, done, tmo, cb_oe, unused_ok;
  assign dec = !isa_aen && isa_addr[9:3] == BASE_ADDR[9:3];
  // commits happen on the strobe's rising edge, using address/data sampled while it was low
  assign wr_stb = dec_q && !iow_q && isa_iow;
  assign clr_stb = dec_q && !ior_q && isa_ior && off_q == OFF_STATUS;
  assign start = wr_stb && off_q == OFF_CMD && !busy;
  assign q_r_debug = dec && !isa_iow;
  assign isa_chrdy = !(dec && !isa_ior && isa_addr[2:1] == 2'b00 && busy);
  assign cb_addr = air_q[AIR_ADDR_MSB:0];
  assign isa_data = dec && !isa_ior ? rd_mux : 8'hzz;
  assign cb_data = cb_oe ? wr_data_q : 16'hzzzz;
  always_comb begin
    wr_data_d = {wr_stb && off_q == OFF_DATA_HI ? wdat_q : wr_data_q[15:8],
                 wr_stb && off_q == OFF_DATA_LO ? wdat_q : wr_data_q[7:0]};
    air_d = {wr_stb && off_q == OFF_AIR_HI ? wdat_q : air_q[15:8],
             wr_stb && off_q == OFF_AIR_LO ? wdat_q : air_q[7:0]};
    f_d = start ? wdat_q[4:0] : f_q;
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_X] = x_lat;
    status[ST_LAM] = lam_q;
    status[ST_DONE] = done;
    status[ST_TMO] = tmo;
    case (isa_addr[2:0])
      OFF_DATA_LO: rd_mux = rd_data[7:0];
      OFF_DATA_HI: rd_mux = rd_data[15:8];
      OFF_CMD:     rd_mux = {3'b000, f_q};
      OFF_STATUS:  rd_mux = status;
      OFF_AIR_LO:  rd_mux = air_q[7:0];
      OFF_AIR_HI:  rd_mux = air_q[15:8];
      default:     rd_mux = 8'h00;
    endcase
  end
  always_ff @(posedge isa_clk or negedge isa_reset)
    if (!isa_reset) begin
      iow_q <= 1'b0;
      ior_q <= 1'b0;
      dec_q <= 1'b0;
      off_q <= '0;
      wdat_q <= '0;
      wr_data_q <= '0;
      air_q <= '0;
      f_q <= '0;
      lam_s_q <= 1'b0;
      lam_q <= 1'b0;
    end else begin
      iow_q <= isa_iow;
      ior_q <= isa_ior;
      dec_q <= dec;
      off_q <= isa_addr[2:0];
      wdat_q <= isa_data;
      wr_data_q <= wr_data_d;
      air_q <= air_d;
      f_q <= f_d;
      lam_s_q <= !cb_prr;
      lam_q <= lam_s_q;
    end
  sm2201_camac_cycle #(.CAMAC_TIMEOUT(CAMAC_TIMEOUT)) u_cycle (
    .clk(isa_clk), .rst_n(isa_reset), .start_i(start), .clr_i(clr_stb), .f_i(wdat_q[4:0]),
    .cb_zk4_i(cb_zk4), .cb_cx1_i(cb_cx1), .cb_data_i(cb_data),
    .busy_o(busy), .x_o(x_lat), .done_o(done), .timeout_o(tmo),
    .b1_o(cb_b_b1), .drive_o(cb_oe), .rdata_o(rd_data)
  );
`ifdef SM2201_ISA_IRQ_EN
  assign isa_irq = air_q[AIR_IRQ_EN] && (lam_q || done) ? 8'(1 << IRQ_LINE) : 8'h00;
  assign unused_ok = isa_ale;
`else
  assign unused_ok = ^{isa_ale, IRQ_LINE[0]};
`endif
endmodule

// File: tb/tb_sm2201_interface_board.sv
// tb_sm2201_interface_board: scoreboarded ISA reads plus inline CAMAC bus checks
module tb_sm2201_interface_board;
  logic isa_clk = 0, isa_reset = 0, isa_ior = 1, isa_iow = 1, isa_ale = 0, isa_aen = 0;
  logic [9:0] isa_addr = '0;
  logic cb_prr = 1, cb_zk4 = 1, cb_cx1 = 0;
  logic isa_chrdy, q_r_debug, cb_b_b1;
  logic [11:0] cb_addr;
  logic [7:0] isa_drv = '0;
  logic isa_oe = 0;
  logic [15:0] cb_drv = '0;
  logic cb_oe = 0;
  wire [7:0] isa_data;
  wire [15:0] cb_data;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  string nm_q[$];
`ifdef SM2201_ISA_IRQ_EN
  logic [7:0] isa_irq;
`endif
  assign isa_data = isa_oe ? isa_drv : 8'hzz;
  assign cb_data = cb_oe ? cb_drv : 16'hzzzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu_isa
    pullup (isa_data[g]);
  end
  for (genvar g = 0; g < 16; g++) begin : g_pu_cb
    pullup (cb_data[g]);
  end
  always #5 isa_clk = ~isa_clk;

  sm2201_interface_board dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_ior(isa_ior), .isa_iow(isa_iow),
    .isa_addr(isa_addr), .isa_data(isa_data), .isa_ale(isa_ale), .isa_aen(isa_aen),
    .isa_chrdy(isa_chrdy), .q_r_debug(q_r_debug), .cb_prr(cb_prr), .cb_zk4(cb_zk4),
    .cb_cx1(cb_cx1), .cb_data(cb_data), .cb_addr(cb_addr), .cb_b_b1(cb_b_b1)
`ifdef SM2201_ISA_IRQ_EN
    , .isa_irq(isa_irq)
`endif
  );

  task automatic isa_write(input logic [9:0] a, input logic [7:0] d, input logic aen, output logic dbg);
    @(negedge isa_clk);
    isa_addr = a; isa_aen = aen; isa_drv = d; isa_oe = 1; isa_iow = 0;
    @(negedge isa_clk);
    #1 dbg = q_r_debug;
    @(negedge isa_clk);
    isa_iow = 1;
    @(negedge isa_clk);
    isa_oe = 0; isa_aen = 0;
  endtask

  // expected byte queued when the strobe starts, retired when the bus is sampled
  task automatic isa_read(input logic [9:0] a, input logic [7:0] e, input string nm);
    logic [7:0] got, want;
    string n;
    @(negedge isa_clk);
    isa_addr = a; isa_ior = 0;
    exp_q.push_back(e); nm_q.push_back(nm);
    @(negedge isa_clk);
    got = isa_data; isa_ior = 1;
    want = exp_q.pop_front(); n = nm_q.pop_front();
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL %s: got %h want %h", n, got, want); end
    @(negedge isa_clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge isa_clk);
    #1;
    n_chk++;
    if ({cb_b_b1, isa_chrdy, q_r_debug, cb_addr} !== {1'b0, 1'b1, 1'b0, 12'h000}) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", {cb_b_b1, isa_chrdy, q_r_debug, cb_addr}, 15'b010000000000000);
    end
    n_chk++;
    if (cb_data !== 16'hFFFF) begin n_fail++; $display("FAIL reset_cb_hiz: got %h want ffff", cb_data); end
    isa_reset = 1;
    isa_read(10'h104, 8'h00, "reset_status");
    isa_read(10'h106, 8'h00, "reset_air_lo");
  endtask

  task automatic test_air;
    logic dbg;
    isa_write(10'h106, 8'hA6, 0, dbg);
    n_chk++;
    if (dbg !== 1'b1) begin n_fail++; $display("FAIL air_qrdebug: got %b want 1", dbg); end
    isa_write(10'h107, 8'h00, 0, dbg);
    n_chk++;
    if (cb_addr !== 12'h0A6) begin n_fail++; $display("FAIL air_cbaddr: got %h want 0a6", cb_addr); end
    isa_read(10'h106, 8'hA6, "air_lo");
    isa_write(10'h107, 8'hF5, 0, dbg);
    n_chk++;
    if (cb_addr !== 12'h5A6) begin n_fail++; $display("FAIL air_cbaddr_hi: got %h want 5a6", cb_addr); end
    isa_read(10'h107, 8'hF5, "air_hi_reserved");
  endtask

  task automatic test_camac_read;
    logic dbg;
    isa_write(10'h102, 8'h00, 0, dbg);
    #1;
    n_chk++;
    if (cb_b_b1 !== 1'b1) begin n_fail++; $display("FAIL rd_dir: got %b want 1", cb_b_b1); end
    cb_drv = 16'h5A3C; cb_oe = 1; cb_cx1 = 1; cb_zk4 = 0;
    repeat (3) @(negedge isa_clk);
    cb_zk4 = 1;
    repeat (2) @(negedge isa_clk);
    cb_oe = 0;
    isa_read(10'h100, 8'h3C, "rd_data_lo");
    isa_read(10'h101, 8'h5A, "rd_data_hi");
    isa_read(10'h104, 8'h0A, "rd_status");
    isa_read(10'h104, 8'h02, "rd_status_cleared");
  endtask

  task automatic test_camac_write;
    logic dbg;
    cb_cx1 = 0;
    isa_write(10'h100, 8'h34, 0, dbg);
    isa_write(10'h101, 8'h12, 0, dbg);
    isa_write(10'h102, 8'h10, 0, dbg);
    #1;
    n_chk++;
    if (cb_b_b1 !== 1'b0) begin n_fail++; $display("FAIL wr_dir: got %b want 0", cb_b_b1); end
    n_chk++;
    if (cb_data !== 16'h1234) begin n_fail++; $display("FAIL wr_drive: got %h want 1234", cb_data); end
    @(negedge isa_clk);
    isa_addr = 10'h101; isa_ior = 0;
    #1;
    n_chk++;
    if (isa_chrdy !== 1'b0) begin n_fail++; $display("FAIL wr_chrdy_busy: got %b want 0", isa_chrdy); end
    isa_ior = 1;
    isa_write(10'h102, 8'h05, 0, dbg);
    #1;
    n_chk++;
    if (cb_data !== 16'h1234) begin n_fail++; $display("FAIL wr_drive_hold: got %h want 1234", cb_data); end
    @(negedge isa_clk);
    cb_zk4 = 0;
    @(negedge isa_clk);
    cb_zk4 = 1;
    repeat (2) @(negedge isa_clk);
    #1;
    n_chk++;
    if (cb_data !== 16'hFFFF) begin n_fail++; $display("FAIL wr_release: got %h want ffff", cb_data); end
    isa_read(10'h100, 8'h3C, "wr_rdata_kept");
    isa_read(10'h104, 8'h08, "wr_status");
    isa_read(10'h102, 8'h10, "wr_cmd_busy_ignored");
  endtask

  task automatic test_timeout;
    logic dbg;
    isa_write(10'h102, 8'h00, 0, dbg);
    repeat (240) @(negedge isa_clk);
    isa_read(10'h104, 8'h01, "tmo_still_busy");
    repeat (30) @(negedge isa_clk);
    #1;
    n_chk++;
    if (cb_data !== 16'hFFFF) begin n_fail++; $display("FAIL tmo_cb_hiz: got %h want ffff", cb_data); end
    isa_read(10'h104, 8'h18, "tmo_status");
    cb_prr = 0;
    repeat (3) @(negedge isa_clk);
    isa_read(10'h104, 8'h04, "lam_status");
    cb_prr = 1;
    repeat (3) @(negedge isa_clk);
  endtask

  task automatic test_decode;
    logic dbg;
    isa_write(10'h106, 8'hFF, 1, dbg);
    n_chk++;
    if (dbg !== 1'b0) begin n_fail++; $display("FAIL dec_aen_qrdebug: got %b want 0", dbg); end
    isa_write(10'h0F0, 8'hFF, 0, dbg);
    n_chk++;
    if (dbg !== 1'b0) begin n_fail++; $display("FAIL dec_other_qrdebug: got %b want 0", dbg); end
    isa_read(10'h106, 8'hA6, "dec_air_unchanged");
    isa_write(10'h103, 8'hFF, 0, dbg);
    isa_read(10'h103, 8'h00, "dec_off3");
    isa_read(10'h105, 8'h00, "dec_off5");
    @(negedge isa_clk);
    isa_addr = 10'h106; isa_aen = 1; isa_ior = 0;
    #1;
    n_chk++;
    if (isa_data !== 8'hFF) begin n_fail++; $display("FAIL dec_aen_hiz: got %h want ff", isa_data); end
    isa_ior = 1; isa_aen = 0;
  endtask

  task automatic test_reset_mid;
    logic dbg;
    isa_write(10'h106, 8'h55, 0, dbg);
    isa_write(10'h107, 8'h03, 0, dbg);
    isa_write(10'h100, 8'h77, 0, dbg);
    isa_write(10'h102, 8'h10, 0, dbg);
    repeat (3) @(negedge isa_clk);
    isa_reset = 0;
    #1;
    n_chk++;
    if ({cb_b_b1, cb_addr} !== 13'h0000) begin n_fail++; $display("FAIL rst_mid_outs: got %h want 0000", {cb_b_b1, cb_addr}); end
    n_chk++;
    if (cb_data !== 16'hFFFF) begin n_fail++; $display("FAIL rst_mid_cb_hiz: got %h want ffff", cb_data); end
    repeat (2) @(negedge isa_clk);
    isa_reset = 1;
    repeat (3) @(negedge isa_clk);
    isa_read(10'h104, 8'h00, "rst_mid_status");
    isa_read(10'h102, 8'h00, "rst_mid_cmd");
    isa_read(10'h100, 8'h00, "rst_mid_data");
    isa_read(10'h106, 8'h00, "rst_mid_air_lo");
    isa_read(10'h107, 8'h00, "rst_mid_air_hi");
  endtask

  initial begin
    test_reset;
    test_air;
    test_camac_read;
    test_camac_write;
    test_timeout;
    test_decode;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
